// File: rtl/win_icon_square.sv
// Win-icon placement/animation: drops a 32x32 icon under gravity, blinks it, then holds it,
// and produces the registered per-pixel inside/offset signals for the bitmap stage.
module win_icon_square #(
    parameter int OBJECT_WIDTH  = 32,
    parameter int OBJECT_HEIGHT = 32,
    parameter int START_X       = 304,
    parameter int START_Y       = 0,
    parameter int TARGET_Y      = 224,
    parameter int GRAVITY       = 1,
    parameter int MAX_SPEED     = 16,
    parameter int BLINK_PERIOD  = 8,
    parameter int BLINK_FRAMES  = 64
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        winEvent,
    input  logic        clearEvent,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        InsideRectangle,
    output logic [10:0] topLeftY,
    output logic        animDone
);

    typedef enum logic [1:0] {S_IDLE, S_DROP, S_BLINK, S_SHOW} state_t;

    state_t      r_state, w_state_nxt;
    logic [10:0] r_topLeftY, w_y_nxt;
    logic [4:0]  r_speed, w_speed_nxt, w_speed_new;
    logic [6:0]  r_blinkCnt, w_blink_nxt;
    logic [5:0]  w_speed_inc;
    logic [11:0] w_y_sum;
    logic        w_visible;
    logic        w_blink_odd;
    logic        w_inside;
    logic [11:0] w_px12, w_py12, w_top12;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state    <= S_IDLE;
            r_topLeftY <= 11'(START_Y);
            r_speed    <= '0;
            r_blinkCnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_topLeftY <= w_y_nxt;
            r_speed    <= w_speed_nxt;
            r_blinkCnt <= w_blink_nxt;
        end
    end

    // Speed saturates before it is added, so the landing frame uses the clamped speed.
    always_comb begin
        w_speed_inc = {1'b0, r_speed} + 6'(GRAVITY);
        w_speed_new = (w_speed_inc > 6'(MAX_SPEED)) ? 5'(MAX_SPEED) : w_speed_inc[4:0];
        w_y_sum     = {1'b0, r_topLeftY} + {7'd0, w_speed_new};
        w_state_nxt = r_state;
        w_y_nxt     = r_topLeftY;
        w_speed_nxt = r_speed;
        w_blink_nxt = r_blinkCnt;
        if (clearEvent) begin
            w_state_nxt = S_IDLE;
            w_y_nxt     = 11'(START_Y);
            w_speed_nxt = '0;
            w_blink_nxt = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (winEvent) begin
                        w_state_nxt = S_DROP;
                        w_y_nxt     = 11'(START_Y);
                        w_speed_nxt = '0;
                    end
                end
                S_DROP: begin
                    if (startOfFrame) begin
                        w_speed_nxt = w_speed_new;
                        if (w_y_sum >= 12'(TARGET_Y)) begin
                            w_y_nxt     = 11'(TARGET_Y);
                            w_blink_nxt = '0;
                            w_state_nxt = S_BLINK;
                        end else begin
                            w_y_nxt = w_y_sum[10:0];
                        end
                    end
                end
                S_BLINK: begin
                    if (startOfFrame) begin
                        if (r_blinkCnt == 7'(BLINK_FRAMES - 1))
                            w_state_nxt = S_SHOW;
                        else
                            w_blink_nxt = r_blinkCnt + 7'd1;
                    end
                end
                S_SHOW: ;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_blink_odd = ((r_blinkCnt / 7'(BLINK_PERIOD)) & 7'd1) != 7'd0;
        w_visible   = 1'b0;
        animDone    = 1'b0;
        unique case (r_state)
            S_IDLE:  w_visible = 1'b0;
            S_DROP:  w_visible = 1'b1;
            S_BLINK: w_visible = !w_blink_odd;
            S_SHOW: begin
                w_visible = 1'b1;
                animDone  = 1'b1;
            end
            default: w_visible = 1'b0;
        endcase
    end

    assign topLeftY = r_topLeftY;

    // Bounds in 12 bits so the box edge near the top of the range cannot wrap.
    assign w_px12   = {1'b0, pixelX};
    assign w_py12   = {1'b0, pixelY};
    assign w_top12  = {1'b0, r_topLeftY};
    assign w_inside = w_visible
                      && (w_px12 >= 12'(START_X))
                      && (w_px12 <  12'(START_X + OBJECT_WIDTH))
                      && (w_py12 >= w_top12)
                      && (w_py12 <  w_top12 + 12'(OBJECT_HEIGHT));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            InsideRectangle <= 1'b0;
            offsetX         <= '0;
            offsetY         <= '0;
        end else begin
            InsideRectangle <= w_inside;
            offsetX         <= w_inside ? (pixelX - 11'(START_X)) : '0;
            offsetY         <= w_inside ? (pixelY - r_topLeftY) : '0;
        end
    end

endmodule

// File: tb/tb_win_icon_square.sv
// Randomized scoreboard bench for win_icon_square against a frame-level animation model.
module tb_win_icon_square;

    localparam int W = 35;  // {inside, offX, offY, topLeftY, animDone}

    logic        clk = 1'b0;
    logic        resetN;
    logic [10:0] pixelX, pixelY;
    logic        startOfFrame, winEvent, clearEvent;
    logic [10:0] offsetX, offsetY, topLeftY;
    logic        InsideRectangle, animDone;

    win_icon_square dut (
        .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame), .winEvent(winEvent), .clearEvent(clearEvent),
        .offsetX(offsetX), .offsetY(offsetY), .InsideRectangle(InsideRectangle),
        .topLeftY(topLeftY), .animDone(animDone)
    );

    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 idle, 1 drop, 2 blink, 3 show.
    int m_phase, m_k, m_j, m_y;

    function automatic int drop_y(input int k);
        int s = 0;
        for (int i = 1; i <= k; i++) s += (i < 16) ? i : 16;
        return s;
    endfunction

    function automatic bit m_visible();
        if (m_phase == 1 || m_phase == 3) return 1'b1;
        if (m_phase == 2) return ((m_j / 8) % 2) == 0;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_k = 0; m_j = 0; m_y = 0;
    endtask

    task automatic model_step(input bit sof, input bit win, input bit clr);
        if (clr) begin
            model_reset();
        end else if (m_phase == 0) begin
            if (win) begin m_phase = 1; m_k = 0; m_y = 0; end
        end else if (m_phase == 1) begin
            if (sof) begin
                m_k++;
                m_y = drop_y(m_k);
                if (m_y >= 224) begin m_y = 224; m_phase = 2; m_j = 0; end
            end
        end else if (m_phase == 2) begin
            if (sof) begin
                m_j++;
                if (m_j == 64) m_phase = 3;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic step(input int px, input int py, input bit sof, input bit win, input bit clr);
        bit ins;
        logic [10:0] ox, oy;
        @(negedge clk);
        ins = m_visible() && px >= 304 && px < 336 && py >= m_y && py < m_y + 32;
        ox  = ins ? 11'(px - 304) : 11'd0;
        oy  = ins ? 11'(py - m_y) : 11'd0;
        model_step(sof, win, clr);
        exp_q.push_back({ins, ox, oy, 11'(m_y), m_phase == 3});
        pixelX = 11'(px); pixelY = 11'(py);
        startOfFrame = sof; winEvent = win; clearEvent = clr;
    endtask

    task automatic rand_step(input bit sof, input bit win, input bit clr);
        int py;
        py = m_y + int'($urandom_range(0, 44)) - 6;
        if (py < 0) py = 0;
        step(int'($urandom_range(298, 342)), py, sof, win, clr);
    endtask

    task automatic frame();
        step(310, m_y + 6, 0, 0, 0);
        rand_step(0, 0, 0);
        rand_step(0, 0, 0);
        rand_step(1, 0, 0);
    endtask

    task automatic do_reset_async();
        @(posedge clk);
        #3;
        resetN = 1'b0;
        #1;
        chk("rst_inside", int'(InsideRectangle), 0);
        chk("rst_offx", int'(offsetX), 0);
        chk("rst_offy", int'(offsetY), 0);
        chk("rst_topy", int'(topLeftY), 0);
        chk("rst_done", int'(animDone), 0);
        model_reset();
        pixelX = '0; pixelY = '0; startOfFrame = 0; winEvent = 0; clearEvent = 0;
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;
    endtask

    // Monitor: every clocked output sample is matched against the oldest expectation.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({InsideRectangle, offsetX, offsetY} != e[34:12]) begin
                    errors++;
                    $display("FAIL pixel: got ins=%0d ox=%0d oy=%0d expected ins=%0d ox=%0d oy=%0d",
                             InsideRectangle, offsetX, offsetY, e[34], e[33:23], e[22:12]);
                end
                checks++;
                if ({topLeftY, animDone} != e[11:0]) begin
                    errors++;
                    $display("FAIL state: got topY=%0d done=%0d expected topY=%0d done=%0d",
                             topLeftY, animDone, e[11:1], e[0]);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ytab[23];
        resetN = 1'b0;
        pixelX = '0; pixelY = '0; startOfFrame = 0; winEvent = 0; clearEvent = 0;
        model_reset();
        #2;
        chk("init_inside", int'(InsideRectangle), 0);
        chk("init_done", int'(animDone), 0);
        chk("init_topy", int'(topLeftY), 0);
        repeat (2) @(negedge clk);
        resetN = 1'b1;

        // Idle frames: icon must stay hidden.
        repeat (5) frame();
        rand_step(0, 0, 0);
        chk("idle_topy", int'(topLeftY), 0);
        chk("idle_done", int'(animDone), 0);

        // Drop with documented landmark heights.
        foreach (ytab[i]) ytab[i] = -1;
        ytab[1] = 1; ytab[2] = 3; ytab[3] = 6; ytab[4] = 10;
        ytab[16] = 136; ytab[17] = 152; ytab[22] = 224;
        step(310, 5, 0, 1, 0);
        for (int f = 1; f <= 22; f++) begin
            frame();
            rand_step(0, 0, 0);
            if (ytab[f] >= 0) chk($sformatf("drop_f%0d", f), int'(topLeftY), ytab[f]);
        end

        // Blink: 64 frames, done only after the last.
        for (int f = 1; f <= 64; f++) begin
            frame();
            if (f == 63) begin
                rand_step(0, 0, 0);
                chk("blink63_done", int'(animDone), 0);
            end
        end
        rand_step(0, 0, 0);
        chk("show_done", int'(animDone), 1);

        // Show-state pixel boundaries.
        step(310, 230, 0, 0, 0);
        step(336, 230, 0, 0, 0);
        chk("in_310_ins", int'(InsideRectangle), 1);
        chk("in_310_ox", int'(offsetX), 6);
        chk("in_310_oy", int'(offsetY), 6);
        step(303, 230, 0, 0, 0);
        chk("out_336_ins", int'(InsideRectangle), 0);
        chk("out_336_ox", int'(offsetX), 0);
        step(335, 255, 0, 0, 0);
        chk("out_303_ins", int'(InsideRectangle), 0);
        step(335, 256, 0, 0, 0);
        chk("corner_ins", int'(InsideRectangle), 1);
        step(304, 224, 0, 0, 0);
        step(304, 223, 0, 0, 0);
        step(310, 230, 0, 1, 0);
        repeat (3) frame();
        rand_step(0, 0, 0);
        chk("show_win_done", int'(animDone), 1);
        chk("show_win_topy", int'(topLeftY), 224);

        // Clear, restart, then clear+win together during drop.
        step(310, 230, 0, 0, 1);
        step(310, 5, 0, 1, 0);
        repeat (5) frame();
        step(310, 20, 0, 1, 1);
        rand_step(0, 0, 0);
        chk("clrwin_topy", int'(topLeftY), 0);
        chk("clrwin_done", int'(animDone), 0);
        repeat (3) frame();
        step(310, 5, 0, 1, 0);
        frame();
        rand_step(0, 0, 0);
        chk("restart_topy", int'(topLeftY), 1);

        // Async reset during a visible blink phase.
        for (int f = 0; f < 40 && m_phase == 1; f++) frame();
        repeat (3) frame();
        step(310, 230, 0, 0, 0);
        do_reset_async();
        repeat (2) frame();

        // Random traffic.
        for (int n = 0; n < 2500; n++)
            rand_step($urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0,
                      $urandom_range(0, 199) == 0);

        for (int n = 0; n < 10 && exp_q.size() > 0; n++) @(posedge clk);
        #3;
        chk("drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
